timer_scheduler: RTL and testbench

Round-robin scheduler that shares one single-shot delay timer among NREQ requesters. It grants one requester at a time, pulses the timer's START input, and waits for the timer's one-cycle READY pulse. It then signals completion to the granted requester. A watchdog aborts the transaction if READY never arrives. The scheduler sits between requester blocks and the timer; the timer itself is instantiated outside this block.

---
 rtl/timer_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/timer_scheduler.sv | 121 ++++++++++++
 tb/tb_timer_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the timer scheduler and its round-robin arbiter.
package timer_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE_ST,
    ERR_ST
  } state_t;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 260;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from ptr+1, wrapping.
// Zero latency; no backpressure, valid is low when nothing requests.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         winner,
  output logic                    valid
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // Offsets start at 1 so the last winner is visited last.
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one single-shot timer among NREQ requesters; grant one, pulse START, wait READY or watchdog.
// Grant one cycle after REQ seen in IDLE; later requests wait while BUSY (no preemption).
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] DONE,
  output logic            ERR,
  output logic            BUSY,
  output logic            TMR_START,
  input  logic            TMR_READY
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] g, g_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          live, live_n;

  logic [NREQ-1:0] win_oh;
  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] gnt_oh;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (REQ),
    .ptr    (ptr),
    .winner (win_oh),
    .valid  (win_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) win_idx = PW'(i);
    end
  end

  assign gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << g;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      ptr   <= PW'(NREQ - 1);
      g     <= '0;
      cnt   <= '0;
      live  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      g     <= g_n;
      cnt   <= cnt_n;
      live  <= live_n;
    end
  end

  // live tracks whether the granted requester kept REQ up; a drop suppresses DONE
  // without putting REQ on a combinational path to the outputs.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    g_n       = g;
    cnt_n     = cnt;
    live_n    = live;
    GNT       = '0;
    DONE      = '0;
    ERR       = 1'b0;
    TMR_START = 1'b0;
    BUSY      = (state != IDLE);
    case (state)
      IDLE: begin
        if (win_vld) begin
          g_n     = win_idx;
          live_n  = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        GNT       = gnt_oh;
        TMR_START = 1'b1;
        cnt_n     = '0;
        live_n    = live & REQ[g];
        state_n   = WAIT;
      end
      WAIT: begin
        GNT    = gnt_oh;
        live_n = live & REQ[g];
        if (TMR_READY) begin
          state_n = DONE_ST;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = ERR_ST;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE_ST: begin
        GNT     = gnt_oh;
        if (live) DONE = gnt_oh;
        ptr_n   = g;
        state_n = IDLE;
      end
      ERR_ST: begin
        GNT     = gnt_oh;
        ERR     = 1'b1;
        ptr_n   = g;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with NREQ=4, TIMEOUT=20 and an 8-cycle behavioural timer.
module tb_timer_scheduler;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [3:0] DONE;
  logic       ERR;
  logic       BUSY;
  logic       TMR_START;
  logic       TMR_READY;

  int n_checks = 0;
  int n_fail   = 0;

  logic       tmr_en;
  logic       inject;
  logic       t_run;
  logic       t_rdy;
  logic [3:0] t_cnt;
  logic       auto_drop;

  int         start_cnt;
  int         done_cnt;
  int         done_bad;
  int         multi_gnt;
  logic [3:0] gq[$];

  always #5 CLK = ~CLK;

  timer_scheduler #(.NREQ(4), .TIMEOUT(20)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .REQ       (REQ),
    .GNT       (GNT),
    .DONE      (DONE),
    .ERR       (ERR),
    .BUSY      (BUSY),
    .TMR_START (TMR_START),
    .TMR_READY (TMR_READY)
  );

  // READY is high in the seventh cycle after the cycle START was sampled.
  always @(posedge CLK) begin
    if (RESET) begin
      t_run <= 1'b0;
      t_cnt <= '0;
      t_rdy <= 1'b0;
    end else begin
      t_rdy <= 1'b0;
      if (TMR_START) begin
        t_run <= 1'b1;
        t_cnt <= 4'd1;
      end else if (t_run) begin
        if (t_cnt == 4'd6) begin
          t_run <= 1'b0;
          t_rdy <= tmr_en;
        end else begin
          t_cnt <= t_cnt + 4'd1;
        end
      end
    end
  end

  assign TMR_READY = t_rdy | inject;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (TMR_START) begin
      start_cnt++;
      gq.push_back(GNT);
    end
    if (DONE != 4'b0) begin
      done_cnt++;
      if (DONE != GNT) done_bad++;
    end
    if ($countones(GNT) > 1) multi_gnt++;
    if (auto_drop) REQ = REQ & ~(DONE | (ERR ? GNT : 4'b0));
  endtask

  task automatic clr_counts();
    start_cnt = 0;
    done_cnt  = 0;
    done_bad  = 0;
    multi_gnt = 0;
    gq.delete();
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && BUSY; i++) step();
    chk("idle_bound", BUSY, 0);
  endtask

  initial begin
    RESET     = 1'b1;
    REQ       = 4'b1111;
    tmr_en    = 1'b1;
    inject    = 1'b0;
    auto_drop = 1'b1;
    clr_counts();

    // 1: reset hold, then requester 0 has first priority
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_outs", {GNT, DONE, ERR, BUSY, TMR_START}, 0);
    end
    RESET = 1'b0;
    step();
    chk("first_gnt", GNT, 4'b0001);
    REQ = 4'b0001;
    wait_idle(30);

    // 2: single request timing
    REQ = 4'b0100;
    step();
    chk("t2_gnt_t1", GNT, 4'b0100);
    chk("t2_start_t1", TMR_START, 1);
    step();
    chk("t2_start_t2", TMR_START, 0);
    chk("t2_gnt_t2", GNT, 4'b0100);
    repeat (5) step();
    chk("t2_rdy_t7", TMR_READY, 0);
    step();
    chk("t2_rdy_t8", TMR_READY, 1);
    chk("t2_done_t8", DONE, 4'b0000);
    step();
    chk("t2_done_t9", DONE, 4'b0100);
    step();
    chk("t2_busy_t10", BUSY, 0);

    // 3: all requesting, rotation from a fresh pointer
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    clr_counts();
    auto_drop = 1'b0;
    REQ = 4'b1111;
    for (int i = 0; i < 80 && done_cnt < 5; i++) step();
    REQ = 4'b0000;
    auto_drop = 1'b1;
    chk("t3_dones", done_cnt, 5);
    chk("t3_starts", start_cnt, 5);
    chk("t3_done_gnt", done_bad, 0);
    chk("t3_multi_gnt", multi_gnt, 0);
    chk("t3_nseq", gq.size(), 5);
    for (int k = 0; k < 5 && k < gq.size(); k++) begin
      chk($sformatf("t3_order%0d", k), gq[k], 4'b0001 << (k % 4));
    end
    step();
    chk("t3_idle", BUSY, 0);

    // 4: requester 1 cancels inside WAIT, requester 2 is next
    clr_counts();
    REQ = 4'b0010;
    step();
    chk("t4_gnt", GNT, 4'b0010);
    step();
    step();
    REQ = 4'b0100;
    repeat (7) step();
    chk("t4_idle_t10", BUSY, 0);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_one_start", start_cnt, 1);
    step();
    chk("t4_next_gnt", GNT, 4'b0100);
    wait_idle(30);

    // 5a: timer never answers, watchdog fires
    tmr_en = 1'b0;
    REQ = 4'b1000;
    step();
    chk("t5_start", TMR_START, 1);
    repeat (20) step();
    chk("t5_err_t21", ERR, 0);
    step();
    chk("t5_err_t22", ERR, 1);
    chk("t5_gnt_t22", GNT, 4'b1000);
    step();
    chk("t5_gnt_t23", GNT, 4'b0000);
    chk("t5_busy_t23", BUSY, 0);

    // 5b: READY coincides with the timeout cycle
    REQ = 4'b0001;
    step();
    repeat (20) step();
    inject = 1'b1;
    step();
    inject = 1'b0;
    chk("t5b_done", DONE, 4'b0001);
    chk("t5b_err", ERR, 0);
    step();
    chk("t5b_idle", BUSY, 0);
    inject = 1'b1;
    step();
    inject = 1'b0;
    chk("t5c_rdy_idle", {BUSY, GNT, DONE}, 0);
    tmr_en = 1'b1;

    // 6: reset in the middle of requester 3's WAIT
    REQ = 4'b1000;
    step();
    chk("t6_gnt3", GNT, 4'b1000);
    step();
    step();
    RESET = 1'b1;
    REQ = 4'b1001;
    step();
    chk("t6_rst_outs", {GNT, DONE, ERR, BUSY, TMR_START}, 0);
    RESET = 1'b0;
    step();
    chk("t6_gnt0", GNT, 4'b0001);
    REQ = 4'b0001;
    wait_idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
